// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: 2-flop rxd synchroniser, mid-bit sampling, valid/ready byte output
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit between data and stop)
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam logic [13:0] HALF_CNT = 14'(CLKS_PER_BIT / 2 - 1);
  localparam logic [13:0] FULL_CNT = 14'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                 state_q;
  logic [13:0]            cnt_q;
  logic [13:0]            cnt_d;
  logic [2:0]             bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_d;
  logic                   sync1_q;
  logic                   rxd_s_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   framing_err_q;
  logic                   overrun_err_q;
  logic                   parity_bad_d;

`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q;
  logic                   parity_err_q;
`endif

  // Two-flop synchroniser; both flops reset to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
    end
  end

  // Next-value helpers: counter increment, LSB-first right shift, parity check
  always_comb begin
    cnt_d   = cnt_q + 14'd1;
    shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
    parity_bad_d = (^shift_q) ^ par_bit_q;
`else
    parity_bad_d = 1'b0;
`endif
  end

  // Receive FSM with registered byte output, handshake and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 14'd0;
      bit_idx_q     <= 3'd0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      // Error outputs are single-cycle pulses
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
      // A consumed byte clears valid unless a new byte loads below on this edge
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= 14'd0;
          if (!rxd_s_q) begin
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q <= 14'd0;
            if (!rxd_s_q) begin
              state_q   <= DATA;
              bit_idx_q <= 3'd0;
            end else begin
              // Line went back high before mid start bit: a glitch, not a frame
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        DATA: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q   <= 14'd0;
            shift_q <= shift_d;
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state_q   <= PARITY;
`else
              state_q   <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q     <= 14'd0;
            par_bit_q <= rxd_s_q;
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif

        STOP: begin
          if (cnt_q == FULL_CNT) begin
            // Leave at mid stop bit so a following start edge is not missed
            cnt_q   <= 14'd0;
            state_q <= IDLE;
            if (!rxd_s_q) begin
              framing_err_q <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (parity_bad_d) begin
              parity_err_q <= 1'b1;
            end
`endif
            if (rxd_s_q && !parity_bad_d) begin
              if (rx_valid_q && !rx_ready) begin
                // Previous byte still pending: keep it, drop the new one
                overrun_err_q <= 1'b1;
              end else begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= 14'd0;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core (CLKS_PER_BIT=16, DATA_BITS=8)
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       framing_err;
  logic       overrun_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int fr_cnt = 0;
  int ov_cnt = 0;
  int par_cnt = 0;
  int valid_cyc = 0;

  logic [7:0] exp_q[$];

  logic       prev_fr = 1'b0;
  logic       prev_ov = 1'b0;
  logic       prev_par = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         bad_par;
    int         exp_fr;
    int         exp_par;
    int         exp_valid;
  } vec_t;

  vec_t vecs[$];

  uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    fr_cnt = 0;
    ov_cnt = 0;
    par_cnt = 0;
    valid_cyc = 0;
  endtask

  // Drives the first nbits bits of a frame (start, data LSB first, [parity], stop)
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit bad_par, input int nbits);
    logic bits[11];
    int   nb;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[nb++] = (^d) ^ bad_par;
`endif
    bits[nb++] = 1'b1;
    for (int i = 0; i < nb && i < nbits; i++) begin
      if (i == nb - 1 && !stop_ok) begin
        // Low across the mid-bit sample only, then back to idle
        rxd = 1'b0;
        repeat (12) tick();
        rxd = 1'b1;
        repeat (CPB - 12) tick();
      end else begin
        rxd = bits[i];
        repeat (CPB) tick();
      end
    end
  endtask

  // Monitor/scoreboard: pops expected bytes on each transfer, watches pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (framing_err) begin
        fr_cnt++;
        check("framing_pulse_width", prev_fr, 0);
      end
      if (overrun_err) begin
        ov_cnt++;
        check("overrun_pulse_width", prev_ov, 0);
      end
      if (parity_err) begin
        par_cnt++;
        check("parity_pulse_width", prev_par, 0);
      end
      if (rx_valid) valid_cyc++;
      if (rx_valid && prev_valid && !prev_ready) check("rx_data_hold", rx_data, prev_data);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          failures++;
          checks++;
          $display("FAIL unexpected_byte actual=%0h expected=none", rx_data);
        end else begin
          check("rx_data_order", rx_data, exp_q.pop_front());
        end
      end
    end
    prev_fr = framing_err;
    prev_ov = overrun_err;
    prev_par = parity_err;
    prev_valid = rx_valid;
    prev_ready = rx_ready;
    prev_data = rx_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 0, 0, 1});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 1, 0, 0});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 0, 0, 1});
    vecs.push_back('{8'h5A, 1'b1, 1'b0, 0, 0, 1});
    vecs.push_back('{8'hC3, 1'b1, 1'b0, 0, 0, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 1, 0});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 0, 0, 1});
    vecs.push_back('{8'h07, 1'b0, 1'b1, 1, 1, 0});
`endif

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_errors", {framing_err, overrun_err, parity_err}, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Table-driven single frames, rx_ready=1
    for (int v = 0; v < vecs.size(); v++) begin
      clear_counts();
      if (vecs[v].exp_valid != 0) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].bad_par, 11);
      repeat (30) tick();
      @(negedge clk);
      check($sformatf("v%0d_framing", v), fr_cnt, vecs[v].exp_fr);
      check($sformatf("v%0d_parity", v), par_cnt, vecs[v].exp_par);
      check($sformatf("v%0d_overrun", v), ov_cnt, 0);
      check($sformatf("v%0d_valid_cycles", v), valid_cyc, vecs[v].exp_valid);
      check($sformatf("v%0d_pending", v), exp_q.size(), 0);
      check($sformatf("v%0d_busy_idle", v), busy, 0);
    end

    // Start glitch: rxd low for 5 cycles
    clear_counts();
    rxd = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("glitch_busy_high", busy, 1);
    rxd = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", valid_cyc, 0);
    check("glitch_no_errors", fr_cnt + ov_cnt + par_cnt, 0);

    // Overrun: rx_ready low across two frames
    clear_counts();
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 11);
    send_frame(8'h22, 1'b1, 1'b0, 11);
    repeat (10) tick();
    @(negedge clk);
    check("overrun_count", ov_cnt, 1);
    check("overrun_valid_held", rx_valid, 1);
    check("overrun_data_held", rx_data, 8'h11);
    rx_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("overrun_drain_valid", rx_valid, 0);
    check("overrun_drain_pending", exp_q.size(), 0);
    check("overrun_no_framing", fr_cnt, 0);

    // Back-to-back frames, no idle gap
    clear_counts();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0, 11);
    send_frame(8'hFF, 1'b1, 1'b0, 11);
    repeat (30) tick();
    @(negedge clk);
    check("b2b_valid_cycles", valid_cyc, 2);
    check("b2b_pending", exp_q.size(), 0);
    check("b2b_errors", fr_cnt + ov_cnt + par_cnt, 0);

    // Reset during data bit 4 of 0x5A
    clear_counts();
    send_frame(8'h5A, 1'b1, 1'b0, 5);
    rxd = 1'b1;
    repeat (8) tick();
    check("midframe_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_errors", {framing_err, overrun_err, parity_err}, 0);
    repeat (20) tick();
    clear_counts();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 11);
    repeat (30) tick();
    @(negedge clk);
    check("post_reset_valid_cycles", valid_cyc, 1);
    check("post_reset_pending", exp_q.size(), 0);
    check("post_reset_errors", fr_cnt + ov_cnt + par_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
